// File: rtl/cga_attrib_pipe_pkg.sv
// cga_pkg: shared constants, types and helpers for the CGA attribute pipe.
//   RGBI_W       width of the raw CGA colour index (RGBI)
//   color_sel_e  which colour source drives a pixel (FG, BG, GFX, OVERSCAN, BLANK)
//   gfx320_color 320-dot graphics colour from the colour-select register
package cga_pkg;

    localparam int RGBI_W = 4;

    typedef enum logic [2:0] {
        FG,
        BG,
        GFX,
        OVERSCAN,
        BLANK
    } color_sel_e;

    // Code 0 is the background colour from the register. Other codes use
    // the palette-select bit (reg[5]) as LSB unless B/W mode substitutes c0.
    function automatic logic [RGBI_W-1:0] gfx320_color(
        input logic [7:0] color_reg,
        input logic       c1,
        input logic       c0,
        input logic       bw
    );
        if ({c1, c0} == 2'b00) begin
            return color_reg[3:0];
        end
        return {color_reg[4], c1, c0, bw ? c0 : color_reg[5]};
    endfunction

endpackage

// File: rtl/cga_attrib_pipe_if.sv
// cga_attrib_pipe_if: video bus between the serialiser and the attribute pipe.
//   master: serialiser side, drives attribute/mode/sync/dot/palette inputs,
//           receives pix_out, hsync_out, vsync_out, de_out.
//   slave : attribute pipe side.
interface cga_attrib_pipe_if #(
    parameter int COLOR_BITS = 4
);
    logic [7:0]            att_byte;
    logic [7:0]            cga_color_reg;
    logic                  grph_mode;
    logic                  bw_mode;
    logic                  mode_640;
    logic                  blink_enabled;
    logic                  display_enable;
    logic                  cursor;
    logic                  hsync;
    logic                  vsync;
    logic                  pix_in;
    logic                  c0;
    logic                  c1;
    logic                  pix_640;
    logic                  pal_we;
    logic [3:0]            pal_addr;
    logic [COLOR_BITS-1:0] pal_data;
    logic [COLOR_BITS-1:0] pix_out;
    logic                  hsync_out;
    logic                  vsync_out;
    logic                  de_out;

    modport master (
        output att_byte, cga_color_reg, grph_mode, bw_mode, mode_640,
               blink_enabled, display_enable, cursor, hsync, vsync,
               pix_in, c0, c1, pix_640, pal_we, pal_addr, pal_data,
        input  pix_out, hsync_out, vsync_out, de_out
    );

    modport slave (
        input  att_byte, cga_color_reg, grph_mode, bw_mode, mode_640,
               blink_enabled, display_enable, cursor, hsync, vsync,
               pix_in, c0, c1, pix_640, pal_we, pal_addr, pal_data,
        output pix_out, hsync_out, vsync_out, de_out
    );
endinterface

// File: rtl/cga_attrib_pipe_blink_gen.sv
// cga_blink_gen: cursor and character blink derived from vsync.
//   clk, reset_n  pixel clock, async active-low reset
//   vsync         raw vertical sync (rising edges are frames)
//   cursor_blink  toggles every CURSOR_FRAMES frames
//   char_blink    toggles on every 0->1 of cursor_blink
module cga_blink_gen #(
    parameter int CURSOR_FRAMES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vsync,
    output logic cursor_blink,
    output logic char_blink
);
    localparam int CNT_W = (CURSOR_FRAMES > 1) ? $clog2(CURSOR_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CURSOR_FRAMES - 1);

    logic             vsync_q;
    logic [CNT_W-1:0] count;
    logic             vs_rise;

    assign vs_rise = vsync & ~vsync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q      <= 1'b0;
            count        <= '0;
            cursor_blink <= 1'b0;
            char_blink   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (vs_rise) begin
                if (count == CNT_LAST) begin
                    count        <= '0;
                    cursor_blink <= ~cursor_blink;
                    if (!cursor_blink) begin
                        char_blink <= ~char_blink;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/cga_attrib_pipe.sv
// cga_attrib_pipe: registered CGA attribute/colour mux.
//   clk, reset_n  pixel clock, async active-low reset
//   bus (slave)   attribute, mode, sync, dot and palette inputs;
//                 pix_out (COLOR_BITS), hsync_out, vsync_out, de_out, all
//                 delayed PIPE_STAGES clocks from the sampled inputs.
// Optional feature: define CGA_ATTRIB_PALETTE_EN for a 16-entry palette
// looked up in stage 2 (requires PIPE_STAGES >= 2). Without it pix_out is
// the zero-extended RGBI index and pal_* are ignored.
module cga_attrib_pipe
    import cga_pkg::*;
#(
    parameter int COLOR_BITS    = 4,
    parameter int PIPE_STAGES   = 2,
    parameter int CURSOR_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cga_attrib_pipe_if.slave      bus
);
    if (COLOR_BITS < RGBI_W) begin : g_bad_width
        $error("cga_attrib_pipe: COLOR_BITS must be >= 4");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("cga_attrib_pipe: PIPE_STAGES must be 1..4");
    end
    if (CURSOR_FRAMES < 1) begin : g_bad_frames
        $error("cga_attrib_pipe: CURSOR_FRAMES must be >= 1");
    end

    logic cursor_blink;
    logic char_blink;

    cga_blink_gen #(
        .CURSOR_FRAMES(CURSOR_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset_n     (reset_n),
        .vsync       (bus.vsync),
        .cursor_blink(cursor_blink),
        .char_blink  (char_blink)
    );

    color_sel_e        sel;
    logic              dot;
    logic [RGBI_W-1:0] bg_color;
    logic [RGBI_W-1:0] rgbi;

    always_comb begin
        bg_color = bus.blink_enabled ? {1'b0, bus.att_byte[6:4]} : bus.att_byte[7:4];
        dot = (bus.pix_in & ~(bus.blink_enabled & bus.att_byte[7] & ~bus.cursor & char_blink))
            | (bus.cursor & cursor_blink);

        sel = FG;
        if (bus.hsync | bus.vsync) begin
            sel = BLANK;
        end else if (bus.grph_mode & bus.mode_640) begin
            sel = (bus.display_enable & bus.pix_640) ? GFX : BLANK;
        end else if (!bus.display_enable) begin
            sel = OVERSCAN;
        end else if (bus.grph_mode) begin
            sel = GFX;
        end else begin
            sel = dot ? FG : BG;
        end

        rgbi = '0;
        case (sel)
            FG:       rgbi = bus.att_byte[3:0];
            BG:       rgbi = bg_color;
            GFX:      rgbi = bus.mode_640 ? bus.cga_color_reg[3:0]
                                          : gfx320_color(bus.cga_color_reg, bus.c1, bus.c0, bus.bw_mode);
            OVERSCAN: rgbi = bus.cga_color_reg[3:0];
            BLANK:    rgbi = '0;
            default:  rgbi = '0;
        endcase
    end

    // Stage 1 (index 0) holds the zero-extended RGBI (already 0 when blank);
    // stage 2 optionally replaces it with the palette entry.
    logic [COLOR_BITS-1:0] pix_pipe [PIPE_STAGES];
    logic                  hs_pipe  [PIPE_STAGES];
    logic                  vs_pipe  [PIPE_STAGES];
    logic                  de_pipe  [PIPE_STAGES];
    logic [COLOR_BITS-1:0] stage2_pix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_pipe[0] <= '0;
            hs_pipe[0]  <= 1'b0;
            vs_pipe[0]  <= 1'b0;
            de_pipe[0]  <= 1'b0;
        end else begin
            pix_pipe[0] <= COLOR_BITS'(rgbi);
            hs_pipe[0]  <= bus.hsync;
            vs_pipe[0]  <= bus.vsync;
            de_pipe[0]  <= bus.display_enable;
        end
    end

    for (genvar g = 1; g < PIPE_STAGES; g++) begin : g_stage
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pix_pipe[g] <= '0;
                hs_pipe[g]  <= 1'b0;
                vs_pipe[g]  <= 1'b0;
                de_pipe[g]  <= 1'b0;
            end else begin
                pix_pipe[g] <= (g == 1) ? stage2_pix : pix_pipe[g-1];
                hs_pipe[g]  <= hs_pipe[g-1];
                vs_pipe[g]  <= vs_pipe[g-1];
                de_pipe[g]  <= de_pipe[g-1];
            end
        end
    end

`ifdef CGA_ATTRIB_PALETTE_EN
    if (PIPE_STAGES < 2) begin : g_bad_palette
        $error("cga_attrib_pipe: palette lookup needs PIPE_STAGES >= 2");
    end

    logic [COLOR_BITS-1:0] palette [16];
    logic                  pal_we_q;
    logic [RGBI_W-1:0]     pal_addr_q;
    logic [COLOR_BITS-1:0] pal_data_q;
    logic                  s1_blank;

    // The write is registered alongside stage 1 and committed while that
    // pixel's lookup happens, so a pixel presented with the write still
    // reads the old entry and the next pixel sees the new one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                palette[i[3:0]] <= COLOR_BITS'(i);
            end
            pal_we_q   <= 1'b0;
            pal_addr_q <= '0;
            pal_data_q <= '0;
            s1_blank   <= 1'b0;
        end else begin
            pal_we_q   <= bus.pal_we;
            pal_addr_q <= bus.pal_addr;
            pal_data_q <= bus.pal_data;
            s1_blank   <= (sel == BLANK);
            if (pal_we_q) begin
                palette[pal_addr_q] <= pal_data_q;
            end
        end
    end

    assign stage2_pix = s1_blank ? '0 : palette[pix_pipe[0][RGBI_W-1:0]];
`else
    logic unused_pal;
    assign unused_pal = &{1'b0, bus.pal_we, bus.pal_addr, bus.pal_data};
    assign stage2_pix = pix_pipe[0];
`endif

    assign bus.pix_out   = pix_pipe[PIPE_STAGES-1];
    assign bus.hsync_out = hs_pipe[PIPE_STAGES-1];
    assign bus.vsync_out = vs_pipe[PIPE_STAGES-1];
    assign bus.de_out    = de_pipe[PIPE_STAGES-1];
endmodule

// File: tb/tb_cga_attrib_pipe.sv
// Testbench for cga_attrib_pipe: directed checks with literal expectations
// plus randomized stimulus compared each cycle against a behavioural model.
module tb_cga_attrib_pipe;
    localparam int CB = 4;
    localparam int PS = 2;
    localparam int CF = 8;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    cga_attrib_pipe_if #(.COLOR_BITS(CB)) bus ();

    cga_attrib_pipe #(
        .COLOR_BITS   (CB),
        .PIPE_STAGES  (PS),
        .CURSOR_FRAMES(CF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [CB-1:0] pix;
        logic          hs;
        logic          vs;
        logic          de;
    } exp_t;

    int            m_edges;
    bit            m_prev_vs;
    logic [CB-1:0] m_pal [16];
    exp_t          m_q [$];

    function automatic exp_t model_pixel();
        exp_t       e;
        bit         blank;
        bit         cur_on, chr_on, hidden, lit;
        logic [3:0] c, fg, bg;
        int         code;
        cur_on = ((m_edges / CF) % 2) == 1;
        chr_on = (((m_edges + CF) / (2 * CF)) % 2) == 1;
        blank  = 0;
        c      = 4'h0;
        if (bus.hsync || bus.vsync) begin
            blank = 1;
        end else if (bus.grph_mode && bus.mode_640) begin
            if (bus.display_enable && bus.pix_640) c = bus.cga_color_reg[3:0];
            else blank = 1;
        end else if (!bus.display_enable) begin
            c = bus.cga_color_reg[3:0];
        end else if (bus.grph_mode) begin
            code = 2 * int'(bus.c1) + int'(bus.c0);
            if (code == 0) c = bus.cga_color_reg[3:0];
            else c = 4'(8 * int'(bus.cga_color_reg[4]) + 2 * code
                        + int'(bus.bw_mode ? bus.c0 : bus.cga_color_reg[5]));
        end else begin
            fg     = bus.att_byte[3:0];
            bg     = bus.blink_enabled ? 4'(bus.att_byte[6:4]) : bus.att_byte[7:4];
            hidden = bus.blink_enabled && bus.att_byte[7] && !bus.cursor && chr_on;
            lit    = (bus.pix_in && !hidden) || (bus.cursor && cur_on);
            c      = lit ? fg : bg;
        end
`ifdef CGA_ATTRIB_PALETTE_EN
        e.pix = blank ? '0 : m_pal[c];
`else
        e.pix = blank ? '0 : CB'(c);
`endif
        e.hs = bus.hsync;
        e.vs = bus.vsync;
        e.de = bus.display_enable;
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_edges   = 0;
                m_prev_vs = 0;
                for (int i = 0; i < 16; i++) m_pal[i] = CB'(i);
                m_q.delete();
                repeat (PS) m_q.push_back('0);
            end else begin
                e = model_pixel();
                m_q.push_back(e);
                void'(m_q.pop_front());
`ifdef CGA_ATTRIB_PALETTE_EN
                if (bus.pal_we) m_pal[bus.pal_addr] = bus.pal_data;
`endif
                if (bus.vsync && !m_prev_vs) m_edges++;
                m_prev_vs = bus.vsync;
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && m_q.size() == PS) begin
                check("model_pix", 32'(bus.pix_out), 32'(m_q[0].pix));
                check("model_hs",  32'(bus.hsync_out), 32'(m_q[0].hs));
                check("model_vs",  32'(bus.vsync_out), 32'(m_q[0].vs));
                check("model_de",  32'(bus.de_out), 32'(m_q[0].de));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        bus.att_byte       = 8'h00;
        bus.cga_color_reg  = 8'h00;
        bus.grph_mode      = 1'b0;
        bus.bw_mode        = 1'b0;
        bus.mode_640       = 1'b0;
        bus.blink_enabled  = 1'b0;
        bus.display_enable = 1'b1;
        bus.cursor         = 1'b0;
        bus.hsync          = 1'b0;
        bus.vsync          = 1'b0;
        bus.pix_in         = 1'b0;
        bus.c0             = 1'b0;
        bus.c1             = 1'b0;
        bus.pix_640        = 1'b0;
        bus.pal_we         = 1'b0;
        bus.pal_addr       = 4'h0;
        bus.pal_data       = '0;
    endtask

    task automatic vs_pulse();
        bus.vsync = 1'b1;
        step();
        bus.vsync = 1'b0;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pix", 32'(bus.pix_out), 32'h0);
        check("reset_hs",  32'(bus.hsync_out), 32'h0);
        check("reset_de",  32'(bus.de_out), 32'h0);
        #1;
        reset_n = 1'b1;

        // Text: att 0x1E, fg E / bg 1, latency exactly PS cycles.
        bus.att_byte = 8'h1E;
        step(); step(); step();
        check("text_bg_steady", 32'(bus.pix_out), 32'h1);
        bus.pix_in = 1'b1;
        step();
        check("text_latency1", 32'(bus.pix_out), 32'h1);
        bus.pix_in = 1'b0;
        step();
        check("text_fg", 32'(bus.pix_out), 32'hE);
        step();
        check("text_bg", 32'(bus.pix_out), 32'h1);

        // Blink: 16 frames, char blink on from frame 8, cursor on 8..15.
        bus.att_byte      = 8'h8F;
        bus.blink_enabled = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.vsync  = 1'b1;
            step();
            bus.vsync  = 1'b0;
            bus.cursor = 1'b0;
            bus.pix_in = 1'b1;
            step();
            bus.cursor = 1'b1;
            bus.pix_in = 1'b0;
            step();
            check("blink_char", 32'(bus.pix_out), (i >= 8) ? 32'h0 : 32'hF);
            step();
            check("blink_cursor", 32'(bus.pix_out), (i >= 8 && i < 16) ? 32'hF : 32'h0);
        end
        set_idle();

        // 320 graphics, reg 0x30.
        bus.grph_mode     = 1'b1;
        bus.cga_color_reg = 8'h30;
        bus.bw_mode       = 1'b1;
        {bus.c1, bus.c0}  = 2'b10;
        step();
        {bus.c1, bus.c0}  = 2'b00;
        step();
        check("g320_bw_10", 32'(bus.pix_out), 32'hC);
        {bus.c1, bus.c0}  = 2'b01;
        step();
        check("g320_00", 32'(bus.pix_out), 32'h0);
        bus.bw_mode       = 1'b0;
        {bus.c1, bus.c0}  = 2'b10;
        step();
        check("g320_bw_01", 32'(bus.pix_out), 32'hB);
        step();
        check("g320_col_10", 32'(bus.pix_out), 32'hD);

        // hsync blanks in any mode and stays aligned with hsync_out.
        for (int m = 0; m < 3; m++) begin
            set_idle();
            bus.att_byte       = 8'h1E;
            bus.pix_in         = 1'b1;
            bus.cga_color_reg  = 8'h3F;
            bus.grph_mode      = (m != 0);
            bus.mode_640       = (m == 2);
            bus.pix_640        = 1'b1;
            step(); step();
            bus.hsync = 1'b1;
            step();
            check("hs_pre", 32'(bus.hsync_out), 32'h0);
            bus.hsync = 1'b0;
            step();
            check("hs_blank_pix", 32'(bus.pix_out), 32'h0);
            check("hs_out", 32'(bus.hsync_out), 32'h1);
        end
        set_idle();

`ifdef CGA_ATTRIB_PALETTE_EN
        bus.att_byte = 8'h0E;
        bus.pix_in   = 1'b1;
        bus.pal_we   = 1'b1;
        bus.pal_addr = 4'hE;
        bus.pal_data = CB'(5);
        step();
        bus.pal_we = 1'b0;
        step();
        check("pal_old", 32'(bus.pix_out), 32'hE);
        step();
        check("pal_new", 32'(bus.pix_out), 32'h5);
        set_idle();
`endif

        // Reset mid-frame; blink counter must restart.
        repeat (5) vs_pulse();
        bus.att_byte = 8'h0F;
        bus.pix_in   = 1'b1;
        step(); step();
        check("prereset_pix", 32'(bus.pix_out), 32'hF);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_pix", 32'(bus.pix_out), 32'h0);
        check("midreset_hs",  32'(bus.hsync_out), 32'h0);
        check("midreset_vs",  32'(bus.vsync_out), 32'h0);
        check("midreset_de",  32'(bus.de_out), 32'h0);
        step();
        reset_n = 1'b1;
        set_idle();
        repeat (7) vs_pulse();
        bus.att_byte = 8'h0F;
        bus.cursor   = 1'b1;
        step(); step();
        check("restart_7", 32'(bus.pix_out), 32'h0);
        set_idle();
        vs_pulse();
        bus.att_byte = 8'h0F;
        bus.cursor   = 1'b1;
        step(); step();
        check("restart_8", 32'(bus.pix_out), 32'hF);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bus.att_byte       = 8'($urandom);
            bus.cga_color_reg  = 8'($urandom);
            bus.grph_mode      = ($urandom_range(0, 1) == 1);
            bus.bw_mode        = ($urandom_range(0, 1) == 1);
            bus.mode_640       = ($urandom_range(0, 2) == 0);
            bus.blink_enabled  = ($urandom_range(0, 1) == 1);
            bus.display_enable = ($urandom_range(0, 3) != 0);
            bus.cursor         = ($urandom_range(0, 3) == 0);
            bus.hsync          = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) bus.vsync = ~bus.vsync;
            bus.pix_in         = ($urandom_range(0, 1) == 1);
            bus.c0             = ($urandom_range(0, 1) == 1);
            bus.c1             = ($urandom_range(0, 1) == 1);
            bus.pix_640        = ($urandom_range(0, 1) == 1);
            bus.pal_we         = ($urandom_range(0, 3) == 0);
            bus.pal_addr       = 4'($urandom);
            bus.pal_data       = CB'($urandom);
            step();
        end
        set_idle();
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
